// File: rtl/lcd_bus_arbiter.sv
// rtl/lcd_bus_arbiter.sv - two-port byte arbiter and HD44780 4-bit bus sequencer
// Purpose: runs the 4-bit-mode power-on init (nibbles 3,3,3,2), then grants
//   bytes from two requesters and strobes each out as high/low nibbles with
//   E timing and post-byte settle waits (long wait after clear/home).
// Ports: CLK rising-edge clock; RST async active-low reset;
//   req0/rs0/data0 -> ack0 and req1/rs1/data1 -> ack1 byte requesters
//   (ack is a one-cycle pulse in the IDLE cycle the byte is latched);
//   init_done, busy status; RS, E, D4-D7 LCD pins (D4 = LSB).
// Option: define LCD_ARB_FIXED_PRIO_EN for fixed priority (port 0 always
//   wins contention); default build is round-robin.
`timescale 1ns/1ps
module lcd_bus_arbiter #(
  parameter int E_HIGH_CYC = 1,
  parameter int E_LOW_CYC  = 1,
  parameter int SHORT_WAIT = 2,
  parameter int LONG_WAIT  = 64,
  parameter int INIT_WAIT  = 64
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       req0,
  input  logic       rs0,
  input  logic [7:0] data0,
  output logic       ack0,
  input  logic       req1,
  input  logic       rs1,
  input  logic [7:0] data1,
  output logic       ack1,
  output logic       init_done,
  output logic       busy,
  output logic       RS,
  output logic       E,
  output logic       D4,
  output logic       D5,
  output logic       D6,
  output logic       D7
);

  // One down-counter serves the E high/low phases and all waits.
  localparam int MAX_WA  = (LONG_WAIT > INIT_WAIT) ? LONG_WAIT : INIT_WAIT;
  localparam int MAX_W   = (MAX_WA > SHORT_WAIT) ? MAX_WA : SHORT_WAIT;
  localparam int MAX_E   = (E_HIGH_CYC > E_LOW_CYC) ? E_HIGH_CYC : E_LOW_CYC;
  localparam int MAX_CNT = (MAX_W > MAX_E) ? MAX_W : MAX_E;
  localparam int CW      = $clog2(MAX_CNT + 1);

  localparam logic [CW-1:0] E_HI_LD  = CW'(E_HIGH_CYC - 1);
  localparam logic [CW-1:0] E_LO_LD  = CW'(E_LOW_CYC - 1);
  localparam logic [CW-1:0] SHORT_LD = CW'(SHORT_WAIT - 1);
  localparam logic [CW-1:0] LONG_LD  = CW'(LONG_WAIT - 1);
  localparam logic [CW-1:0] INIT_LD  = CW'(INIT_WAIT - 1);

  typedef enum logic [2:0] {
    S_INIT_NIB,
    S_INIT_WAIT,
    S_IDLE,
    S_NIB_SETUP,
    S_NIB_E_HI,
    S_NIB_E_LO,
    S_BYTE_WAIT
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [1:0]    init_idx;
  logic          second_nib;
  logic [3:0]    lo_nib;
  logic          long_wait;
  logic          init_done_q;
  logic          e_q;
  logic          rs_q;
  logic [3:0]    d_q;

  logic          gnt0;
  logic          gnt1;
  logic          sel_rs;
  logic [7:0]    sel_data;

`ifndef LCD_ARB_FIXED_PRIO_EN
  // 1 = port 1 was granted last, so port 0 wins the next contention.
  logic          last_grant;
`endif

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
`ifdef LCD_ARB_FIXED_PRIO_EN
    gnt0 = req0;
    gnt1 = req1 && !req0;
`else
    if (req0 && req1) begin
      gnt0 = last_grant;
      gnt1 = !last_grant;
    end else begin
      gnt0 = req0;
      gnt1 = req1;
    end
`endif
  end

  assign sel_rs   = gnt0 ? rs0 : rs1;
  assign sel_data = gnt0 ? data0 : data1;

  // Ack is decoded in the grant cycle so the requester sees it while the
  // byte is being latched and may change req/data on the next cycle.
  assign ack0 = (state == S_IDLE) && gnt0;
  assign ack1 = (state == S_IDLE) && gnt1;
  assign busy = (state != S_IDLE);

  assign init_done          = init_done_q;
  assign E                  = e_q;
  assign RS                 = rs_q;
  assign {D7, D6, D5, D4}   = d_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= S_INIT_NIB;
      cnt         <= '0;
      init_idx    <= 2'd0;
      second_nib  <= 1'b0;
      lo_nib      <= 4'h0;
      long_wait   <= 1'b0;
      init_done_q <= 1'b0;
      e_q         <= 1'b0;
      rs_q        <= 1'b0;
      d_q         <= 4'h0;
`ifndef LCD_ARB_FIXED_PRIO_EN
      last_grant  <= 1'b1;
`endif
    end else begin
      case (state)
        // Loads the init nibble; the strobe itself uses the shared setup path.
        S_INIT_NIB: begin
          rs_q  <= 1'b0;
          d_q   <= (init_idx == 2'd3) ? 4'h2 : 4'h3;
          e_q   <= 1'b0;
          state <= S_NIB_SETUP;
        end

        S_INIT_WAIT: begin
          if (cnt == '0) begin
            // init_idx wraps to 0 after the fourth nibble.
            if (init_idx == 2'd0) begin
              init_done_q <= 1'b1;
              state       <= S_IDLE;
            end else begin
              state <= S_INIT_NIB;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        S_IDLE: begin
          e_q <= 1'b0;
          if (gnt0 || gnt1) begin
            rs_q       <= sel_rs;
            d_q        <= sel_data[7:4];
            lo_nib     <= sel_data[3:0];
            long_wait  <= !sel_rs && (sel_data[7:2] == 6'd0);
            second_nib <= 1'b0;
`ifndef LCD_ARB_FIXED_PRIO_EN
            last_grant <= gnt1;
`endif
            state      <= S_NIB_SETUP;
          end
        end

        S_NIB_SETUP: begin
          e_q   <= 1'b1;
          cnt   <= E_HI_LD;
          state <= S_NIB_E_HI;
        end

        S_NIB_E_HI: begin
          if (cnt == '0) begin
            e_q   <= 1'b0;
            cnt   <= E_LO_LD;
            state <= S_NIB_E_LO;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        S_NIB_E_LO: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (!init_done_q) begin
            init_idx <= init_idx + 2'd1;
            if (INIT_WAIT == 0) begin
              if (init_idx == 2'd3) begin
                init_done_q <= 1'b1;
                state       <= S_IDLE;
              end else begin
                state <= S_INIT_NIB;
              end
            end else begin
              cnt   <= INIT_LD;
              state <= S_INIT_WAIT;
            end
          end else if (!second_nib) begin
            second_nib <= 1'b1;
            d_q        <= lo_nib;
            state      <= S_NIB_SETUP;
          end else if (long_wait) begin
            if (LONG_WAIT == 0) begin
              state <= S_IDLE;
            end else begin
              cnt   <= LONG_LD;
              state <= S_BYTE_WAIT;
            end
          end else begin
            if (SHORT_WAIT == 0) begin
              state <= S_IDLE;
            end else begin
              cnt   <= SHORT_LD;
              state <= S_BYTE_WAIT;
            end
          end
        end

        S_BYTE_WAIT: begin
          if (cnt == '0) begin
            state <= S_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        default: begin
          e_q   <= 1'b0;
          state <= S_INIT_NIB;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// tb/tb_lcd_bus_arbiter.sv - scoreboard bench for lcd_bus_arbiter
`timescale 1ns/1ps
module tb_lcd_bus_arbiter;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       req0, rs0, req1, rs1;
  logic [7:0] data0, data1;
  logic       ack0, ack1, init_done, busy, RS, E, D4, D5, D6, D7;

  always #5 CLK = ~CLK;

  lcd_bus_arbiter dut (
    .CLK(CLK), .RST(RST),
    .req0(req0), .rs0(rs0), .data0(data0), .ack0(ack0),
    .req1(req1), .rs1(rs1), .data1(data1), .ack1(ack1),
    .init_done(init_done), .busy(busy),
    .RS(RS), .E(E), .D4(D4), .D5(D5), .D6(D6), .D7(D7)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct packed {logic rs; logic [3:0] nib;} strobe_t;
  typedef struct {int port; int gap;} ack_t;

  strobe_t    exp_strobe[$];
  ack_t       exp_ack[$];
  logic [8:0] q0[$];
  logic [8:0] q1[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_init();
    exp_strobe.push_back('{1'b0, 4'h3});
    exp_strobe.push_back('{1'b0, 4'h3});
    exp_strobe.push_back('{1'b0, 4'h3});
    exp_strobe.push_back('{1'b0, 4'h2});
  endtask

  // gap: expected cycles since the previous ack, -1 = not checked
  task automatic expect_byte(input int port, input logic rs, input logic [7:0] d, input int gap);
    exp_ack.push_back('{port, gap});
    exp_strobe.push_back('{rs, d[7:4]});
    exp_strobe.push_back('{rs, d[3:0]});
  endtask

  // Monitor / scoreboard
  logic    e_prev = 1'b0;
  logic    id_prev = 1'b0;
  int      e_width = 0;
  int      last_ehi = 0;
  int      last_init_rise = -1;
  int      last_ack = -1;
  strobe_t s;
  ack_t    a;

  always @(negedge CLK) begin
    if (!RST) begin
      e_prev = 1'b0; id_prev = 1'b0; e_width = 0;
      last_init_rise = -1; last_ack = -1;
    end else begin
      if (E) begin
        e_width++;
        last_ehi = cyc;
        if (!e_prev) begin
          if (!init_done) begin
            if (last_init_rise >= 0) chk("init_strobe_gap", cyc - last_init_rise, 68);
            last_init_rise = cyc;
          end
          if (exp_strobe.size() == 0) chk("unexpected_strobe", 1, 0);
          else begin
            s = exp_strobe.pop_front();
            chk("strobe_rs", RS, s.rs);
            chk("strobe_nibble", {D7, D6, D5, D4}, s.nib);
          end
        end
      end else if (e_prev) begin
        chk("e_high_width", e_width, 1);
        e_width = 0;
      end
      if (init_done && !id_prev) begin
        chk("init_done_delay", cyc - last_ehi, 66);
        chk("busy_at_init_done", busy, 0);
      end
      if (ack0 || ack1) begin
        chk("ack_onehot", ack0 && ack1, 0);
        chk("ack_busy", busy, 0);
        chk("ack_init_done", init_done, 1);
        if (exp_ack.size() == 0) chk("unexpected_ack", 1, 0);
        else begin
          a = exp_ack.pop_front();
          chk("ack_port", ack1 ? 1 : 0, a.port);
          if (a.gap >= 0) chk("ack_gap", cyc - last_ack, a.gap);
        end
        last_ack = cyc;
      end
      e_prev = E;
      id_prev = init_done;
    end
  end

  // Requesters: each port presents the head of its queue until acked.
  task automatic present();
    req0 = (q0.size() > 0);
    if (req0) {rs0, data0} = q0[0];
    req1 = (q1.size() > 0);
    if (req1) {rs1, data1} = q1[0];
  endtask

  task automatic run_ports(input int budget);
    int   n;
    logic a0, a1;
    n = 0;
    present();
    while ((q0.size() > 0 || q1.size() > 0) && n < budget) begin
      @(negedge CLK);
      a0 = ack0; a1 = ack1; n++;
      @(posedge CLK); #1;
      if (a0 && q0.size() > 0) q0.delete(0);
      if (a1 && q1.size() > 0) q1.delete(0);
      present();
    end
    chk("port_queues_drained", q0.size() + q1.size(), 0);
  endtask

  task automatic wait_init(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!init_done && n < budget);
    chk("init_done_seen", init_done, 1);
  endtask

  initial begin
    int n;
    req0 = 0; rs0 = 0; data0 = 0;
    req1 = 0; rs1 = 0; data1 = 0;
    RST = 0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_E", E, 0);
    chk("rst_RS", RS, 0);
    chk("rst_D", {D7, D6, D5, D4}, 0);
    chk("rst_ack", {ack1, ack0}, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_busy", busy, 1);

    // Init sequence, then port 0 bytes with short and long waits
    push_init();
    RST = 1;
    wait_init(1000);
    @(posedge CLK); #1;
    expect_byte(0, 1'b1, 8'h48, -1);
    expect_byte(0, 1'b0, 8'h01, 9);
    expect_byte(0, 1'b0, 8'h0C, 71);
    expect_byte(0, 1'b0, 8'h02, 9);
    expect_byte(0, 1'b1, 8'h41, 71);
    q0.push_back(9'h148);
    q0.push_back(9'h001);
    q0.push_back(9'h00C);
    q0.push_back(9'h002);
    q0.push_back(9'h141);
    run_ports(2000);
    repeat (80) @(posedge CLK);
    #1;

    // Reset during E high of a byte: E drops immediately, no resumption
    exp_ack.push_back('{1, -1});
    exp_strobe.push_back('{1'b1, 4'h5});
    req1 = 1; rs1 = 1; data1 = 8'h5A;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!E && n < 200);
    chk("abort_e_high_seen", E, 1);
    #1;
    RST = 0;
    req1 = 0;
    #1;
    chk("abort_e_async_low", E, 0);
    chk("abort_busy", busy, 1);
    repeat (2) @(posedge CLK);
    #1;
    push_init();
    RST = 1;
    wait_init(1000);
    repeat (30) @(posedge CLK);
    #1;

    // Both ports requesting from reset: nothing acked during init,
    // first grant in the first IDLE cycle goes to port 0
    RST = 0;
    push_init();
`ifdef LCD_ARB_FIXED_PRIO_EN
    expect_byte(0, 1'b1, 8'h31, -1);
    expect_byte(0, 1'b1, 8'h32, 9);
    expect_byte(1, 1'b1, 8'h51, 9);
    expect_byte(1, 1'b1, 8'h52, 9);
`else
    expect_byte(0, 1'b1, 8'h31, -1);
    expect_byte(1, 1'b1, 8'h51, 9);
    expect_byte(0, 1'b1, 8'h32, 9);
    expect_byte(1, 1'b1, 8'h52, 9);
`endif
    q0.push_back(9'h131);
    q0.push_back(9'h132);
    q1.push_back(9'h151);
    q1.push_back(9'h152);
    present();
    repeat (2) @(posedge CLK);
    #1;
    RST = 1;
    run_ports(2000);
    repeat (20) @(posedge CLK);
    #1;

    chk("strobes_left", exp_strobe.size(), 0);
    chk("acks_left", exp_ack.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lcd_bus_arbiter.md
Name: lcd_bus_arbiter

Overview:
- Shares the single HD44780-style 4-bit LCD bus (RS, E, D4-D7) between two byte-level requesters, e.g. text streamer and command/cursor client.
- Runs the power-on 4-bit-mode init sequence itself.
- Serialises each granted byte into two nibble strobes with correct E timing and post-byte settle delays.
- Sits between the badge content generators and the LCD pins; replaces per-generator hand-sequenced nibble counters.

Parameters:
E_HIGH_CYC, 1, cycles E is held high per nibble (>=1)
E_LOW_CYC, 1, cycles E is low with data held after each strobe (>=1)
SHORT_WAIT, 2, idle cycles after an ordinary byte
LONG_WAIT, 64, idle cycles after clear/home commands
INIT_WAIT, 64, idle cycles after each init nibble

Ports:
CLK  input  1  system clock, all logic on rising edge
RST  input  1  asynchronous reset, active-low
req0  input  1  requester 0 has a byte pending
rs0  input  1  requester 0 RS value (0=command, 1=data)
data0  input  8  requester 0 byte
ack0  output  1  one-cycle pulse: requester 0 byte accepted
req1  input  1  requester 1 has a byte pending
rs1  input  1  requester 1 RS value
data1  input  8  requester 1 byte
ack1  output  1  one-cycle pulse: requester 1 byte accepted
init_done  output  1  high once init sequence has completed
busy  output  1  high whenever FSM is not in IDLE
RS  output  1  LCD register select
E  output  1  LCD enable strobe
D4, D5, D6, D7  output  1 each  LCD data nibble, D4 = LSB

Behaviour:
- Reset (RST low, async): E=0, RS=0, D4-D7=0, ack0=ack1=0, init_done=0, busy=1, RR pointer = port 0 preferred. FSM enters INIT at nibble index 0. Release restarts init from scratch; reset mid-byte drops E immediately, no partial byte is resumed.
- States: INIT_NIB, INIT_WAIT, IDLE, NIB_SETUP, NIB_E_HI, NIB_E_LO, BYTE_WAIT.
- Nibble strobe, used everywhere:
  - 1 setup cycle: RS/D driven, E=0.
  - E_HIGH_CYC cycles: E=1.
  - E_LOW_CYC cycles: E=0, RS/D held.
- INIT:
  - Nibbles 0x3, 0x3, 0x3, 0x2 with RS=0, each followed by INIT_WAIT cycles.
  - Then init_done=1 (stays until reset) and FSM goes to IDLE.
  - Requests during INIT are not acked.
- IDLE:
  - E=0; RS/D hold last driven values.
  - If any req is high, grant and pulse the chosen ack for exactly one cycle in the cycle the byte/RS are latched.
  - Requester must hold req/rs/data stable until it sees ack; it may drop or re-raise req the cycle after ack.
- Arbitration:
  - Round-robin. Only one req high -> that port.
  - Both high -> port not granted last; first-ever contention after reset -> port 0.
  - Never both acks in one cycle.
- Byte transfer: high nibble (data[7:4]) strobe, then low nibble (data[3:0]) strobe, RS = latched rs for both. Then BYTE_WAIT:
  - LONG_WAIT cycles if rs=0 and data[7:2]==0 (0x01 clear, 0x02/0x03 home).
  - Otherwise SHORT_WAIT cycles.
  - Then back to IDLE; arbitration next possible in the IDLE cycle.
- Cycle counts (defaults):
  - Byte = 2*(1+1+1)+2 = 8 cycles, plus 1 IDLE/grant cycle = 9 cycles ack-to-ack for back-to-back ordinary bytes.
  - Clear = 6+64+1 = 71 cycles.
- Wait counter width = clog2 of max(LONG_WAIT, INIT_WAIT, SHORT_WAIT)+1.
- A parameter value of 0 for a wait skips BYTE_WAIT/INIT_WAIT entirely.
- busy=0 only in IDLE.

Optional Feature:
- Macro LCD_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, port 0 always wins contention; RR pointer logic not built.
- Undefined (default): round-robin as above.
- All timing identical in both builds.

Test Plan:
- Reset release, no reqs -> E pulses on nibbles 3,3,3,2 with RS=0, each E high 1 cycle and 64 idle cycles after; init_done rises after the 4th wait; busy falls same cycle.
- After init, req0 with rs0=1, data0=0x48 -> ack0 pulse one cycle; D=0x4 then 0x8 strobed with RS=1; next IDLE 9 cycles after ack.
- req0 rs0=0 data0=0x01 -> LONG_WAIT applied: next ack no earlier than 71 cycles later. Data 0x0C (rs=0) uses SHORT_WAIT only.
- req0 and req1 held continuously with distinct bytes -> acks alternate 0,1,0,1 starting with port 0; with LCD_ARB_FIXED_PRIO_EN only ack0 pulses.
- Reqs asserted during INIT -> no ack before init_done; first ack in the first IDLE cycle.
- RST low during NIB_E_HI of a byte -> E=0 asynchronously (before next CLK edge); after release, full init sequence repeats and no ack is issued for the aborted byte.
